// File: rtl/hbm_arb_pkg.sv
// Shared types and constants for the two-requester HBM read arbiter.
package hbm_arb_pkg;

  localparam int ARB_NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } arb_state_e;

endpackage

// File: rtl/hbm_rr_arb2.sv
// Two-way round-robin grant selection (purely combinational).
module hbm_rr_arb2
  import hbm_arb_pkg::*;
(
  input  logic [ARB_NUM_REQ-1:0] req,
  input  logic                   last,
  output logic                   gnt,
  output logic                   valid
);

  // On a tie the requester that was not served last wins; a lone requester always wins.
  always_comb begin
    valid = |req;
    gnt   = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/hbm_rd_arbiter.sv
// Arbitrates two AXI read requesters onto one HBM read port, one burst at a time.
// Optional per-requester grant counters are built when HBM_ARB_STATS_EN is defined.
module hbm_rd_arbiter
  import hbm_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst,
  input  logic [ARB_NUM_REQ-1:0][ADDR_W-1:0] s_araddr,
  input  logic [ARB_NUM_REQ-1:0][7:0]        s_arlen,
  input  logic [ARB_NUM_REQ-1:0]             s_arvalid,
  output logic [ARB_NUM_REQ-1:0]             s_arready,
  output logic [DATA_W-1:0]                  s_rdata,
  output logic [ARB_NUM_REQ-1:0]             s_rvalid,
  output logic [ARB_NUM_REQ-1:0]             s_rlast,
  input  logic [ARB_NUM_REQ-1:0]             s_rready,
  output logic [ADDR_W-1:0]                  m_araddr,
  output logic [7:0]                         m_arlen,
  output logic                               m_arvalid,
  input  logic                               m_arready,
  input  logic [DATA_W-1:0]                  m_rdata,
  input  logic                               m_rlast,
  input  logic                               m_rvalid,
  output logic                               m_rready,
  output logic                               err_len,
  output logic [31:0]                        grant_cnt0,
  output logic [31:0]                        grant_cnt1
);

  arb_state_e        state, state_nxt;
  logic              last_q, gnt_q;
  logic              win, win_valid;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q, cnt_q;
  logic              err_q;
  logic              beat;

  hbm_rr_arb2 u_arb (
    .req   (s_arvalid),
    .last  (last_q),
    .gnt   (win),
    .valid (win_valid)
  );

  assign beat     = m_rvalid & m_rready;
  assign m_araddr = addr_q;
  assign m_arlen  = len_q;
  assign s_rdata  = m_rdata;
  assign err_len  = err_q;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    s_arready = '0;
    s_rvalid  = '0;
    s_rlast   = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    // Handshake outputs are forced low while reset is held, whatever the state register shows.
    if (!ap_rst) begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            s_arready[win] = 1'b1;
            state_nxt      = ST_ADDR;
          end
        end
        ST_ADDR: begin
          m_arvalid = 1'b1;
          if (m_arready) state_nxt = ST_DATA;
        end
        ST_DATA: begin
          m_rready        = s_rready[gnt_q];
          s_rvalid[gnt_q] = m_rvalid;
          s_rlast[gnt_q]  = m_rlast;
          if (m_rvalid && s_rready[gnt_q] && m_rlast) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= ST_IDLE;
      last_q <= 1'b1;
      gnt_q  <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            gnt_q  <= win;
            addr_q <= s_araddr[win];
            len_q  <= s_arlen[win];
          end
        end
        ST_ADDR: begin
          if (m_arready) cnt_q <= len_q;
        end
        ST_DATA: begin
          if (beat) begin
            // Length check: rlast must coincide exactly with the counter reaching zero.
            if (m_rlast) begin
              last_q <= gnt_q;
              if (cnt_q != 8'd0) err_q <= 1'b1;
            end else if (cnt_q == 8'd0) begin
              err_q <= 1'b1;
            end
            if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HBM_ARB_STATS_EN
  logic [31:0] cnt0_q, cnt1_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (s_arvalid[0] && s_arready[0]) cnt0_q <= cnt0_q + 32'd1;
      if (s_arvalid[1] && s_arready[1]) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
// Directed self-checking bench for hbm_rd_arbiter; grant-count expectations follow HBM_ARB_STATS_EN.
module tb_hbm_rd_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
`ifdef HBM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                          ap_clk = 1'b0;
  logic                          ap_rst;
  logic [1:0][ADDR_W-1:0]        s_araddr;
  logic [1:0][7:0]               s_arlen;
  logic [1:0]                    s_arvalid;
  logic [1:0]                    s_arready;
  logic [DATA_W-1:0]             s_rdata;
  logic [1:0]                    s_rvalid;
  logic [1:0]                    s_rlast;
  logic [1:0]                    s_rready;
  logic [ADDR_W-1:0]             m_araddr;
  logic [7:0]                    m_arlen;
  logic                          m_arvalid;
  logic                          m_arready;
  logic [DATA_W-1:0]             m_rdata;
  logic                          m_rlast;
  logic                          m_rvalid;
  logic                          m_rready;
  logic                          err_len;
  logic [31:0]                   grant_cnt0;
  logic [31:0]                   grant_cnt1;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  always #5 ap_clk = ~ap_clk;

  hbm_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .s_araddr   (s_araddr),
    .s_arlen    (s_arlen),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rvalid   (s_rvalid),
    .s_rlast    (s_rlast),
    .s_rready   (s_rready),
    .m_araddr   (m_araddr),
    .m_arlen    (m_arlen),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rlast    (m_rlast),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .err_len    (err_len),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " grant_cnt0"}, grant_cnt0, 32'(exp_cnt0));
    check({tag, " grant_cnt1"}, grant_cnt1, 32'(exp_cnt1));
  endtask

  // Presents a request in IDLE, checks the combinational grant, and takes the edge.
  task automatic request(input logic [1:0] mask, input int g, input logic [63:0] a0, input logic [63:0] a1,
                         input logic [7:0] l0, input logic [7:0] l1, input bit keep);
    s_araddr[0] = a0;
    s_araddr[1] = a1;
    s_arlen[0]  = l0;
    s_arlen[1]  = l1;
    s_arvalid   = mask;
    #1;
    check("s_arready grant", s_arready, (g == 0) ? 2'b01 : 2'b10);
    if (STATS) begin
      if (g == 0) exp_cnt0++;
      else exp_cnt1++;
    end
    next_cycle();
    if (!keep) s_arvalid = 2'b00;
  endtask

  task automatic addr_phase(input logic [63:0] addr, input logic [7:0] len, input int wait_cyc);
    m_arready = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      #1;
      check("m_arvalid held", m_arvalid, 1'b1);
      check("m_araddr held", m_araddr, addr);
      check("m_arlen held", m_arlen, len);
      check("s_arready in ADDR", s_arready, 2'b00);
      next_cycle();
    end
    m_arready = 1'b1;
    #1;
    check("m_arvalid", m_arvalid, 1'b1);
    check("m_araddr", m_araddr, addr);
    check("m_arlen", m_arlen, len);
    next_cycle();
    m_arready = 1'b0;
  endtask

  // Feeds beats until the rlast beat is accepted; rlast is driven on accepted-beat index rlast_at.
  task automatic data_phase(input int g, input int rlast_at, input int exp_beats, input bit toggle);
    int  beats = 0;
    int  cyc   = 0;
    bit  done  = 1'b0;
    logic exp_rdy;
    while (!done && cyc < 40) begin
      exp_rdy     = toggle ? ((cyc % 2) == 0) : 1'b1;
      s_rready    = 2'b11;
      s_rready[g] = exp_rdy;
      m_rvalid    = 1'b1;
      m_rdata     = {16{32'hCAFE_0000 + 32'(beats)}};
      m_rlast     = (beats == rlast_at);
      #1;
      check("m_rready mirror", m_rready, exp_rdy);
      check("s_rvalid", s_rvalid, (g == 0) ? 2'b01 : 2'b10);
      check("s_rlast", s_rlast, m_rlast ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00);
      check("s_rdata", s_rdata, {16{32'hCAFE_0000 + 32'(beats)}});
      check("s_arready in DATA", s_arready, 2'b00);
      if (exp_rdy) begin
        if (beats == rlast_at) done = 1'b1;
        beats++;
      end
      next_cycle();
      cyc++;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b11;
    check("burst completed", done, 1'b1);
    check("beat count", beats, exp_beats);
  endtask

  initial begin
    ap_rst    = 1'b1;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arvalid = 2'b11;
    s_rready  = 2'b11;
    m_arready = 1'b1;
    m_rdata   = '0;
    m_rlast   = 1'b1;
    m_rvalid  = 1'b1;

    // Reset: every handshake output held low even with activity on the inputs.
    next_cycle();
    next_cycle();
    check("rst s_arready", s_arready, 2'b00);
    check("rst s_rvalid", s_rvalid, 2'b00);
    check("rst s_rlast", s_rlast, 2'b00);
    check("rst m_arvalid", m_arvalid, 1'b0);
    check("rst m_rready", m_rready, 1'b0);
    check("rst err_len", err_len, 1'b0);
    check_counts("rst");
    ap_rst    = 1'b0;
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;

    // Three back-to-back ties: 0, 1, 0, with re-arbitration the cycle after rlast.
    request(2'b11, 0, 64'h100, 64'h200, 8'd1, 8'd1, 1'b1);
    addr_phase(64'h100, 8'd1, 0);
    data_phase(0, 1, 2, 1'b0);
    request(2'b11, 1, 64'h100, 64'h200, 8'd1, 8'd1, 1'b1);
    addr_phase(64'h200, 8'd1, 0);
    data_phase(1, 1, 2, 1'b0);
    request(2'b11, 0, 64'h100, 64'h200, 8'd0, 8'd0, 1'b0);
    addr_phase(64'h100, 8'd0, 0);
    data_phase(0, 0, 1, 1'b0);
    check_counts("ties");

    // Req0 alone, 4-beat burst, address accepted after two wait cycles.
    request(2'b01, 0, 64'h1000, 64'h0, 8'd3, 8'd0, 1'b0);
    addr_phase(64'h1000, 8'd3, 2);
    data_phase(0, 3, 4, 1'b0);
    check("A err_len", err_len, 1'b0);

    // Req1 alone with a toggling s_rready; requester 0 must never see s_rvalid.
    request(2'b10, 1, 64'h0, 64'h4000, 8'd0, 8'd3, 1'b0);
    addr_phase(64'h4000, 8'd3, 1);
    data_phase(1, 3, 4, 1'b1);
    check("toggle err_len", err_len, 1'b0);
    check_counts("toggle");

    // Early rlast: arlen 3 but rlast on the second beat.
    request(2'b01, 0, 64'h3000, 64'h0, 8'd3, 8'd0, 1'b0);
    addr_phase(64'h3000, 8'd3, 0);
    data_phase(0, 1, 2, 1'b0);
    check("early rlast err_len", err_len, 1'b1);
    s_arvalid = 2'b01;
    #1;
    check("back in IDLE", s_arready, 2'b01);
    s_arvalid = 2'b00;
    next_cycle();
    check("err_len sticky", err_len, 1'b1);

    // Reset in the middle of a data burst.
    request(2'b10, 1, 64'h0, 64'h5000, 8'd0, 8'd3, 1'b0);
    addr_phase(64'h5000, 8'd3, 0);
    m_rvalid = 1'b1;
    m_rdata  = {16{32'h1234_5678}};
    #1;
    check("pre-rst s_rvalid", s_rvalid, 2'b10);
    next_cycle();
    ap_rst = 1'b1;
    #1;
    check("in-rst s_rvalid", s_rvalid, 2'b00);
    check("in-rst m_rready", m_rready, 1'b0);
    next_cycle();
    ap_rst   = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    #1;
    check("post-rst s_rvalid", s_rvalid, 2'b00);
    check("post-rst s_rlast", s_rlast, 2'b00);
    check("post-rst m_rready", m_rready, 1'b0);
    check("post-rst m_arvalid", m_arvalid, 1'b0);
    check("post-rst s_arready", s_arready, 2'b00);
    check("post-rst err_len", err_len, 1'b0);
    check_counts("post-rst");
    m_rvalid = 1'b0;
    next_cycle();

    // arlen 0: single beat carrying rlast.
    request(2'b01, 0, 64'h2000, 64'h0, 8'd0, 8'd0, 1'b0);
    addr_phase(64'h2000, 8'd0, 0);
    data_phase(0, 0, 1, 1'b0);
    check("arlen0 err_len", err_len, 1'b0);
    check_counts("arlen0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hbm_rd_arbiter.md
HBM_RD_ARBITER -- requirements
Module: hbm_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning AXI address width (dwidth_aximm).
REQ-002 SHALL have parameter DATA_W, default 512, meaning AXI read data width (phit_size).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port ap_clk, input, 1, rising-edge clock for all logic.
REQ-005 SHALL have port ap_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port s_araddr, input, 2xADDR_W, read address from each requester (index 0 and 1).
REQ-007 SHALL have port s_arlen, input, 2x8, AXI burst length minus one, per requester.
REQ-008 SHALL have ports s_arvalid (input) and s_arready (output), each 2 bits, per-requester address handshake.
REQ-009 SHALL have port s_rdata, output, DATA_W, read data broadcast to both requesters.
REQ-010 SHALL have ports s_rvalid and s_rlast (outputs, 2 bits each) and s_rready (input, 2 bits), per-requester data handshake.
REQ-011 SHALL have master ports m_araddr (out, ADDR_W), m_arlen (out, 8), m_arvalid (out, 1), m_arready (in, 1).
REQ-012 SHALL have master ports m_rdata (in, DATA_W), m_rlast (in, 1), m_rvalid (in, 1), m_rready (out, 1).
REQ-013 SHALL have port err_len, output, 1, sticky flag for a burst-length mismatch.
REQ-014 SHALL have ports grant_cnt0 and grant_cnt1, outputs, 32 bits each, count of accepted bursts per requester.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ADDR, DATA.
REQ-016 IDLE: when any s_arvalid is high, SHALL pick a winner g, assert s_arready[g] combinationally in that cycle, capture s_araddr[g]/s_arlen[g] and g, then go to ADDR.
REQ-017 Arbitration SHALL be round-robin: a lone requester wins; if both request, the one not granted last wins.
REQ-018 ADDR: SHALL hold m_arvalid=1 with the captured addr/len until m_arready; on m_arvalid&m_arready, SHALL load beat counter = len and go to DATA.
REQ-019 DATA: SHALL drive m_rready=s_rready[g], s_rvalid[g]=m_rvalid, s_rlast[g]=m_rlast, and keep the non-granted s_rvalid/s_rlast at 0; s_rdata=m_rdata.
REQ-020 DATA: each m_rvalid&m_rready beat SHALL decrement the beat counter.
REQ-021 The burst SHALL end only on a beat with m_rlast=1; the FSM SHALL then return to IDLE and record g as last granted.
REQ-022 SHALL set err_len if m_rlast arrives with counter!=0, or a beat arrives with counter==0 and m_rlast=0; err_len clears only on reset.
REQ-023 SHALL have exactly one burst outstanding; s_arready SHALL be 0 in ADDR and DATA.
REQ-024 The earliest re-arbitration SHALL be the cycle after the rlast beat (no IDLE bypass).
REQ-025 m_arvalid, once asserted, SHALL NOT drop and m_araddr/m_arlen SHALL NOT change before m_arready.
REQ-026 An arlen of 0 SHALL produce a single-beat burst whose first beat carries rlast.

Reset
REQ-027 On ap_rst, SHALL set FSM=IDLE, last granted=1 (requester 0 wins first tie), beat counter=0, err_len=0, grant counters=0.
REQ-028 During reset, SHALL hold s_arready, s_rvalid, s_rlast, m_arvalid and m_rready at 0; an in-flight burst is abandoned.

Configuration
REQ-029 With HBM_ARB_STATS_EN defined, grant_cnt0/1 SHALL increment on each s_arvalid&s_arready of their requester and wrap at 2^32.
REQ-030 Without HBM_ARB_STATS_EN, grant_cnt0/1 SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-031 The FSM state enum and the ARB_NUM_REQ=2 constant SHALL live in shared package hbm_arb_pkg.
REQ-032 Grant selection SHALL be a combinational sub-module hbm_rr_arb2 (inputs req[1:0], last; output gnt, valid).

Verification
REQ-033 Req0 only, addr 0x1000, arlen 3, m_arready after 2 cycles -> m_araddr=0x1000, 4 beats to requester 0, s_rlast[0] on beat 4, err_len=0.
REQ-034 Both requesters raise arvalid in the same cycle after reset -> req0 granted first, req1 next; third tie -> req0.
REQ-035 s_rready[g] toggles 1/0 during a 4-beat burst -> m_rready mirrors it, no beat lost or duplicated, other requester sees no s_rvalid.
REQ-036 arlen 3 but m_rlast on beat 2 -> err_len=1 and FSM returns to IDLE; err_len remains set.
REQ-037 ap_rst asserted mid-DATA -> next cycle all valids/readies are 0, FSM=IDLE, grant counters=0 (STATS build).
REQ-038 arlen 0 -> single beat with s_rlast=1; STATS build shows grant_cnt0=1.
